// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode
// constants, ALU operation codes, instruction classes and per-state strobe decode.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'b0000,
    S_DECODE   = 4'b0001,
    S_ADDR     = 4'b0010,
    S_MEM_LW   = 4'b0011,
    S_WB_LW    = 4'b0100,
    S_EXEC_R   = 4'b0101,
    S_MEM_SW   = 4'b0110,
    S_ALU_PASS = 4'b0111,
    S_BRANCH   = 4'b1000,
    S_EXEC_I   = 4'b1001,
    S_WB_ALU   = 4'b1010,
    S_HALT     = 4'b1111
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_R       = 3'd3,
    CLS_I       = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } class_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT_R = 2'b10;
  localparam logic [1:0] ALU_FUNCT_I = 2'b11;

  // branch marks BRANCH: pcwrite there follows the live ALU zero flag.
  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
  } strobe_t;

  function automatic strobe_t strobes_for(input state_t s);
    strobe_t t;
    t = '0;
    case (s)
      S_FETCH: begin
        t.irwrite = 1'b1;
        t.pcwrite = 1'b1;
        t.aluop   = ALU_ADD;
      end
      S_ADDR: begin
        t.alusrc = 1'b1;
        t.aluop  = ALU_ADD;
      end
      S_MEM_LW: t.memread = 1'b1;
      S_WB_LW: begin
        t.regwrite = 1'b1;
        t.memtoreg = 1'b1;
      end
      S_MEM_SW: t.memwrite = 1'b1;
      S_EXEC_R: begin
        t.alusrc = 1'b0;
        t.aluop  = ALU_FUNCT_R;
      end
      S_EXEC_I: begin
        t.alusrc = 1'b1;
        t.aluop  = ALU_FUNCT_I;
      end
      S_WB_ALU: t.regwrite = 1'b1;
      S_BRANCH: begin
        t.aluop  = ALU_SUB;
        t.pcsrc  = 1'b1;
        t.branch = 1'b1;
      end
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface controle_multiciclo_if #(
  parameter int CNT_W = 32
);
  // enable qualifies every controller edge: with enable=0 nothing advances and
  // the write strobes read 0; there is no backpressure in the other direction.
  logic             enable;
  logic [6:0]       opcode;
  logic             zero;
  logic [3:0]       estado;
  logic             irwrite;
  logic             pcwrite;
  logic             pcsrc;
  logic             alusrc;
  logic [1:0]       aluop;
  logic             memread;
  logic             memwrite;
  logic             regwrite;
  logic             memtoreg;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  enable, opcode, zero,
    output estado, irwrite, pcwrite, pcsrc, alusrc, aluop, memread, memwrite,
           regwrite, memtoreg, halted, illegal, cycle_count, instr_count
  );

  modport slave (
    output enable, opcode, zero,
    input  estado, irwrite, pcwrite, pcsrc, alusrc, aluop, memread, memwrite,
           regwrite, memtoreg, halted, illegal, cycle_count, instr_count
  );
endinterface

// File: rtl/controle_multiciclo_opcode_classifier.sv
// Combinational opcode -> instruction class map; HALT_OPCODE takes priority.
module opcode_classifier
  import controle_multiciclo_pkg::*;
#(
  parameter logic [6:0] HALT_OPCODE = 7'b0000000
) (
  input  logic [6:0] opcode,
  output class_t     op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode == HALT_OPCODE) begin
      op_class = CLS_HALT;
    end else begin
      case (opcode)
        OP_LW:   op_class = CLS_LW;
        OP_SW:   op_class = CLS_SW;
        OP_R:    op_class = CLS_R;
        OP_I:    op_class = CLS_I;
        OP_BEQ:  op_class = CLS_BEQ;
        default: op_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV32I-subset datapath, with saturating cycle and
// retired-instruction counters and a sticky halt flag.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter logic [6:0] HALT_OPCODE = 7'b0000000
) (
  input logic                   clk,
  input logic                   rst_n,
  controle_multiciclo_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, nxt;
  class_t           cls, nxt_cls, op_cls;
  strobe_t          stb;
  logic             started;
  logic             halted_q;
  logic             illegal_q;
  logic             retire;
  logic             bad;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ins;

  opcode_classifier #(.HALT_OPCODE(HALT_OPCODE)) u_classifier (
    .opcode   (bus.opcode),
    .op_class (op_cls)
  );

  always_comb begin
    nxt     = state;
    nxt_cls = cls;
    retire  = 1'b0;
    bad     = 1'b0;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        nxt_cls = op_cls;
        case (op_cls)
          CLS_LW, CLS_SW: nxt = S_ADDR;
          CLS_R:          nxt = S_EXEC_R;
          CLS_I:          nxt = S_EXEC_I;
          CLS_BEQ:        nxt = S_BRANCH;
          CLS_HALT:       nxt = S_HALT;
          default: begin
            nxt = S_FETCH;
            bad = 1'b1;
          end
        endcase
      end
      S_ADDR:     nxt = (cls == CLS_SW) ? S_MEM_SW : S_MEM_LW;
      S_MEM_LW:   nxt = S_WB_LW;
      S_EXEC_R,
      S_EXEC_I:   nxt = S_ALU_PASS;
      S_ALU_PASS: nxt = S_WB_ALU;
      S_WB_LW,
      S_MEM_SW,
      S_WB_ALU,
      S_BRANCH: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_HALT:     nxt = S_HALT;
      default: begin
        nxt = S_FETCH;
        bad = 1'b1;
      end
    endcase
  end

  // The first enabled edge after reset only arms the FETCH strobes; estado stays
  // 0000 so that the first real FETCH cycle starts on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      cls       <= CLS_NONE;
      stb       <= '0;
      started   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cyc       <= '0;
      ins       <= '0;
    end else if (bus.enable) begin
      if (!halted_q && cyc != '1) cyc <= cyc + CNT_ONE;
      if (!started) begin
        started   <= 1'b1;
        stb       <= strobes_for(S_FETCH);
        illegal_q <= 1'b0;
      end else begin
        state     <= nxt;
        cls       <= nxt_cls;
        stb       <= strobes_for(nxt);
        illegal_q <= bad;
        if (nxt == S_HALT) halted_q <= 1'b1;
        if (retire && ins != '1) ins <= ins + CNT_ONE;
      end
    end
  end

  assign bus.estado      = state;
  assign bus.irwrite     = stb.irwrite & bus.enable;
  assign bus.pcwrite     = (stb.pcwrite | (stb.branch & bus.zero)) & bus.enable;
  assign bus.pcsrc       = stb.pcsrc;
  assign bus.alusrc      = stb.alusrc;
  assign bus.aluop       = stb.aluop;
  assign bus.memread     = stb.memread & bus.enable;
  assign bus.memwrite    = stb.memwrite & bus.enable;
  assign bus.regwrite    = stb.regwrite & bus.enable;
  assign bus.memtoreg    = stb.memtoreg;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q & bus.enable;
  assign bus.cycle_count = cyc;
  assign bus.instr_count = ins;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks lw, sw, addi, add, beq, illegal,
// halt, an enable stall and a mid-instruction reset against hand-computed values.
module tb_controle_multiciclo;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;
  localparam logic [6:0] HLT  = 7'b0000000;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  controle_multiciclo_if #(.CNT_W(32)) bus_if ();

  controle_multiciclo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_if.enable = 1'b1;
    bus_if.opcode = LW;
    bus_if.zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_estado", bus_if.estado, 4'b0000);
    chk("rst_irwrite", bus_if.irwrite, 1'b0);
    chk("rst_pcwrite", bus_if.pcwrite, 1'b0);
    chk("rst_halted", bus_if.halted, 1'b0);
    chk("rst_illegal", bus_if.illegal, 1'b0);
    chk("rst_cycles", bus_if.cycle_count, 32'd0);
    chk("rst_instrs", bus_if.instr_count, 32'd0);

    rst_n = 1'b1;
    tick();
    chk("start_estado", bus_if.estado, 4'b0000);
    chk("start_irwrite", bus_if.irwrite, 1'b1);
    chk("start_pcwrite", bus_if.pcwrite, 1'b1);
    chk("start_cycles", bus_if.cycle_count, 32'd1);

    // lw
    tick();
    chk("lw_decode", bus_if.estado, 4'b0001);
    chk("lw_decode_irwrite", bus_if.irwrite, 1'b0);
    tick();
    chk("lw_addr", bus_if.estado, 4'b0010);
    chk("lw_addr_alusrc", bus_if.alusrc, 1'b1);
    chk("lw_addr_memread", bus_if.memread, 1'b0);
    tick();
    chk("lw_mem", bus_if.estado, 4'b0011);
    chk("lw_mem_memread", bus_if.memread, 1'b1);
    chk("lw_mem_regwrite", bus_if.regwrite, 1'b0);
    tick();
    chk("lw_wb", bus_if.estado, 4'b0100);
    chk("lw_wb_regwrite", bus_if.regwrite, 1'b1);
    chk("lw_wb_memtoreg", bus_if.memtoreg, 1'b1);
    chk("lw_wb_memread", bus_if.memread, 1'b0);
    chk("lw_wb_instrs", bus_if.instr_count, 32'd0);
    tick();
    chk("lw_done", bus_if.estado, 4'b0000);
    chk("lw_done_instrs", bus_if.instr_count, 32'd1);
    chk("lw_done_cycles", bus_if.cycle_count, 32'd6);

    // sw
    bus_if.opcode = SW;
    tick();
    chk("sw_decode", bus_if.estado, 4'b0001);
    tick();
    chk("sw_addr", bus_if.estado, 4'b0010);
    tick();
    chk("sw_mem", bus_if.estado, 4'b0110);
    chk("sw_mem_memwrite", bus_if.memwrite, 1'b1);
    chk("sw_mem_regwrite", bus_if.regwrite, 1'b0);
    tick();
    chk("sw_done", bus_if.estado, 4'b0000);
    chk("sw_done_memwrite", bus_if.memwrite, 1'b0);
    chk("sw_done_instrs", bus_if.instr_count, 32'd2);

    // addi
    bus_if.opcode = ADDI;
    tick();
    tick();
    chk("addi_exec", bus_if.estado, 4'b1001);
    chk("addi_aluop", bus_if.aluop, 2'b11);
    chk("addi_alusrc", bus_if.alusrc, 1'b1);
    tick();
    chk("addi_pass", bus_if.estado, 4'b0111);
    chk("addi_pass_regwrite", bus_if.regwrite, 1'b0);
    chk("addi_pass_memwrite", bus_if.memwrite, 1'b0);
    tick();
    chk("addi_wb", bus_if.estado, 4'b1010);
    chk("addi_wb_regwrite", bus_if.regwrite, 1'b1);
    chk("addi_wb_memtoreg", bus_if.memtoreg, 1'b0);
    tick();
    chk("addi_instrs", bus_if.instr_count, 32'd3);

    // add
    bus_if.opcode = ADD;
    tick();
    tick();
    chk("add_exec", bus_if.estado, 4'b0101);
    chk("add_aluop", bus_if.aluop, 2'b10);
    chk("add_alusrc", bus_if.alusrc, 1'b0);
    tick();
    chk("add_pass", bus_if.estado, 4'b0111);
    tick();
    chk("add_wb_regwrite", bus_if.regwrite, 1'b1);
    tick();
    chk("add_done", bus_if.estado, 4'b0000);
    chk("add_instrs", bus_if.instr_count, 32'd4);

    // beq taken, then not taken
    bus_if.opcode = BEQ;
    bus_if.zero   = 1'b1;
    tick();
    tick();
    chk("beq1_state", bus_if.estado, 4'b1000);
    chk("beq1_pcwrite", bus_if.pcwrite, 1'b1);
    chk("beq1_pcsrc", bus_if.pcsrc, 1'b1);
    chk("beq1_aluop", bus_if.aluop, 2'b01);
    tick();
    chk("beq1_done", bus_if.estado, 4'b0000);
    chk("beq1_instrs", bus_if.instr_count, 32'd5);
    bus_if.zero = 1'b0;
    tick();
    tick();
    chk("beq0_state", bus_if.estado, 4'b1000);
    chk("beq0_pcwrite", bus_if.pcwrite, 1'b0);
    chk("beq0_pcsrc", bus_if.pcsrc, 1'b1);
    tick();
    chk("beq0_instrs", bus_if.instr_count, 32'd6);
    chk("beq0_cycles", bus_if.cycle_count, 32'd26);

    // illegal opcode
    bus_if.opcode = BAD;
    tick();
    chk("ill_decode_illegal", bus_if.illegal, 1'b0);
    tick();
    chk("ill_state", bus_if.estado, 4'b0000);
    chk("ill_pulse", bus_if.illegal, 1'b1);
    chk("ill_instrs", bus_if.instr_count, 32'd6);

    // halt
    bus_if.opcode = HLT;
    tick();
    chk("ill_pulse_end", bus_if.illegal, 1'b0);
    tick();
    chk("halt_state", bus_if.estado, 4'b1111);
    chk("halt_flag", bus_if.halted, 1'b1);
    chk("halt_cycles", bus_if.cycle_count, 32'd30);
    repeat (3) tick();
    chk("halt_hold", bus_if.estado, 4'b1111);
    chk("halt_cycles_frozen", bus_if.cycle_count, 32'd30);
    chk("halt_irwrite", bus_if.irwrite, 1'b0);
    chk("halt_instrs", bus_if.instr_count, 32'd6);

    // enable stall in MEM_LW
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", bus_if.halted, 1'b0);
    rst_n = 1'b1;
    bus_if.opcode = LW;
    tick();
    tick();
    tick();
    tick();
    chk("stall_state", bus_if.estado, 4'b0011);
    chk("stall_memread_pre", bus_if.memread, 1'b1);
    bus_if.enable = 1'b0;
    #1;
    chk("stall_memread_off", bus_if.memread, 1'b0);
    repeat (3) tick();
    chk("stall_hold", bus_if.estado, 4'b0011);
    chk("stall_memread", bus_if.memread, 1'b0);
    chk("stall_cycles", bus_if.cycle_count, 32'd4);
    bus_if.enable = 1'b1;
    #1;
    chk("stall_resume_memread", bus_if.memread, 1'b1);
    tick();
    chk("stall_wb", bus_if.estado, 4'b0100);
    tick();
    chk("stall_instrs", bus_if.instr_count, 32'd1);
    chk("stall_total_cycles", bus_if.cycle_count, 32'd6);

    // reset in the middle of MEM_SW
    bus_if.opcode = SW;
    tick();
    tick();
    tick();
    chk("abort_pre_state", bus_if.estado, 4'b0110);
    chk("abort_pre_memwrite", bus_if.memwrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", bus_if.estado, 4'b0000);
    chk("abort_memwrite", bus_if.memwrite, 1'b0);
    chk("abort_cycles", bus_if.cycle_count, 32'd0);
    chk("abort_instrs", bus_if.instr_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
